sram_stream_fifo_ctrl: RTL

- Ready/valid streaming FIFO controller that uses the 256x32 dual-port SRAM wrapper (separate W0 write port, R0 read port) as its storage.
- Sits directly upstream of the SRAM wrapper and drives its W0_* and R0_* ports.
- Hides the macro's 1-cycle read latency behind a 2-entry output prefetch buffer, giving full single-cycle throughput on both sides.
- Used as the sample/bin buffer between spectrometer pipeline stages.

---
 rtl/sram_stream_fifo_ctrl_if.sv | 34 +++
 rtl/sram_stream_fifo_ctrl.sv | 84 ++++++++
 2 files changed

// File: rtl/sram_stream_fifo_ctrl_if.sv
// Stream and SRAM-port bundle for the SRAM-backed FIFO controller.
// The slave view belongs to the controller; the master view belongs to the producer, consumer and SRAM side.
interface sram_stream_fifo_ctrl_if #(
  parameter int ADDR_W = 8,
  parameter int DATA_W = 32,
  parameter int CNT_W  = 9
);
  logic              clear;
  logic              in_valid;
  logic              in_ready;
  logic [DATA_W-1:0] in_data;
  logic              out_valid;
  logic              out_ready;
  logic [DATA_W-1:0] out_data;
  logic [CNT_W-1:0]  count;
  logic              W0_en;
  logic [ADDR_W-1:0] W0_addr;
  logic [DATA_W-1:0] W0_data;
  logic              R0_en;
  logic [ADDR_W-1:0] R0_addr;
  logic [DATA_W-1:0] R0_data;

  modport slave (
    input  clear, in_valid, in_data, out_ready, R0_data,
    output in_ready, out_valid, out_data, count,
           W0_en, W0_addr, W0_data, R0_en, R0_addr
  );

  modport master (
    output clear, in_valid, in_data, out_ready, R0_data,
    input  in_ready, out_valid, out_data, count,
           W0_en, W0_addr, W0_data, R0_en, R0_addr
  );
endinterface

// File: rtl/sram_stream_fifo_ctrl.sv
// Ready/valid FIFO on a 1-cycle-latency dual-port SRAM.
// A 2-entry prefetch buffer hides the read latency, so the FIFO sustains one word per cycle.
module sram_stream_fifo_ctrl #(
  parameter int DEPTH  = 256,
  parameter int ADDR_W = 8,
  parameter int DATA_W = 32,
  parameter int CNT_W  = 9
) (
  input logic clock,
  input logic reset_n,
  sram_stream_fifo_ctrl_if.slave io
);
  localparam logic [ADDR_W:0] FULL_LVL = (ADDR_W+1)'(DEPTH);

  logic [ADDR_W-1:0]           wptr, rptr;
  logic [ADDR_W:0]             used;
  logic                        inflight;
  logic [1:0]                  buf_cnt;
  logic [1:0][DATA_W-1:0]      obuf;

  logic       in_fire, out_fire, rd_issue;
  logic [2:0] occ;

  always_comb begin
    io.in_ready = reset_n && (used != FULL_LVL) && !io.clear;
    in_fire     = io.in_valid && io.in_ready;
    out_fire    = (buf_cnt != 2'd0) && io.out_ready;
    // Buffer slots already claimed once this cycle's pop is accounted for.
    occ         = 3'(buf_cnt) + 3'(inflight);
    rd_issue    = (used != '0) && (occ < (3'd2 + 3'(out_fire))) && !io.clear;

    io.W0_en    = in_fire;
    io.W0_addr  = wptr;
    io.W0_data  = io.in_data;
    io.R0_en    = rd_issue;
    io.R0_addr  = rptr;
    io.out_valid = buf_cnt != 2'd0;
    io.out_data  = obuf[0];
    io.count     = CNT_W'(used) + CNT_W'(buf_cnt) + CNT_W'(inflight);
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      wptr     <= '0;
      rptr     <= '0;
      used     <= '0;
      inflight <= 1'b0;
      buf_cnt  <= 2'd0;
      obuf     <= '0;
    end else if (io.clear) begin
      // Any word returning from the SRAM this cycle is dropped with the rest.
      wptr     <= '0;
      rptr     <= '0;
      used     <= '0;
      inflight <= 1'b0;
      buf_cnt  <= 2'd0;
    end else begin
      wptr     <= wptr + ADDR_W'(in_fire);
      rptr     <= rptr + ADDR_W'(rd_issue);
      used     <= used + (ADDR_W+1)'(in_fire) - (ADDR_W+1)'(rd_issue);
      inflight <= rd_issue;
      case ({inflight, out_fire})
        2'b01: begin
          obuf[0] <= obuf[1];
          buf_cnt <= buf_cnt - 2'd1;
        end
        2'b10: begin
          obuf[buf_cnt[0]] <= io.R0_data;
          buf_cnt          <= buf_cnt + 2'd1;
        end
        2'b11: begin
          // Pop first, then the returning word lands at the new tail.
          if (buf_cnt == 2'd2) begin
            obuf[0] <= obuf[1];
            obuf[1] <= io.R0_data;
          end else begin
            obuf[0] <= io.R0_data;
          end
        end
        default: ;
      endcase
    end
  end
endmodule
